// File: rtl/md_unit_iter.sv
// rtl/md_unit_iter.sv - iterative multiply/divide unit holding the HI/LO pair
// Optional MDU_CANCEL_EN adds a Cancel input that aborts an in-flight op.
module md_unit_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int OP_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Start,
  input  logic [OP_W-1:0]  MDUOP,
  input  logic [1:0]       ReadHILO,
`ifdef MDU_CANCEL_EN
  input  logic             Cancel,
`endif
  output logic             Busy,
  output logic [WIDTH-1:0] MDUResult
);
  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [OP_W-1:0] OP_MULT  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MULTU = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_MADD  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_MADDU = OP_W'(8);
  localparam logic [OP_W-1:0] OP_MSUB  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_MSUBU = OP_W'(10);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic               cancel;
  logic               mul_signed, div_signed, div_ge;
  logic [2*WIDTH-1:0] a_ext, b_ext, product, acc;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   abs_a, abs_b;

`ifdef MDU_CANCEL_EN
  assign cancel = Cancel;
`else
  assign cancel = 1'b0;
`endif

  assign mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
  assign a_ext   = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign b_ext   = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign product = a_ext * b_ext;
  assign acc     = {hi_q, lo_q};

  // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign div_ge  = shifted >= {1'b0, b_q};

  assign div_signed = (MDUOP == OP_DIV);
  assign abs_a = (div_signed && SrcA[WIDTH-1]) ? -SrcA : SrcA;
  assign abs_b = (div_signed && SrcB[WIDTH-1]) ? -SrcB : SrcB;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (Start && !cancel) begin
          a_d  = SrcA;
          b_d  = SrcB;
          op_d = MDUOP;
          case (MDUOP)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              count_d = CNT_W'(MUL_LAT - 1);
              state_d = MUL;
            end
            OP_DIV, OP_DIVU: begin
              quo_d   = abs_a;
              b_d     = abs_b;
              rem_d   = '0;
              qneg_d  = div_signed && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
              rneg_d  = div_signed && SrcA[WIDTH-1];
              dz_d    = (SrcB == '0);
              count_d = CNT_W'(WIDTH - 1);
              state_d = DIV;
            end
            OP_MTHI: hi_d = SrcA;
            OP_MTLO: lo_d = SrcA;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (count_q == '0) begin
          case (op_q)
            OP_MADD, OP_MADDU: {hi_d, lo_d} = acc + product;
            OP_MSUB, OP_MSUBU: {hi_d, lo_d} = acc - product;
            default:           {hi_d, lo_d} = product;
          endcase
          state_d = IDLE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      DIV: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          rem_d = div_ge ? WIDTH'(shifted - {1'b0, b_q}) : shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], div_ge};
          if (count_q == '0) state_d = FIX;
          else               count_d = count_q - 1'b1;
        end
      end
      FIX: begin
        if (!cancel) begin
          // a_q still holds the untouched dividend for the divide-by-zero result.
          if (dz_q) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = qneg_q ? -quo_q : quo_q;
            hi_d = rneg_q ? -rem_q : rem_q;
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign Busy = Start || (state_q != IDLE);

  always_comb begin
    MDUResult = '0;
    case (ReadHILO)
      2'b01:   MDUResult = lo_q;
      2'b10:   MDUResult = hi_q;
      default: MDUResult = '0;
    endcase
  end
endmodule

// File: tb/tb_md_unit_iter.sv
// tb/tb_md_unit_iter.sv - self-checking bench for md_unit_iter (32-bit/lat 5 and 16-bit/lat 1)
module tb_md_unit_iter;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a32, b32, res32;
  logic [15:0] a16, b16, res16;
  logic [3:0]  op32, op16;
  logic [1:0]  rd32, rd16;
  logic        st32, st16, busy32, busy16;
  logic        cancel32, cancel16;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi32, m_lo32, m_hi16, m_lo16;

  always #5 clk = ~clk;

  md_unit_iter #(.WIDTH(32), .MUL_LAT(5), .OP_W(4)) u32 (
    .clk(clk), .reset(reset), .SrcA(a32), .SrcB(b32), .Start(st32), .MDUOP(op32),
    .ReadHILO(rd32),
`ifdef MDU_CANCEL_EN
    .Cancel(cancel32),
`endif
    .Busy(busy32), .MDUResult(res32)
  );

  md_unit_iter #(.WIDTH(16), .MUL_LAT(1), .OP_W(4)) u16 (
    .clk(clk), .reset(reset), .SrcA(a16), .SrcB(b16), .Start(st16), .MDUOP(op16),
    .ReadHILO(rd16),
`ifdef MDU_CANCEL_EN
    .Cancel(cancel16),
`endif
    .Busy(busy16), .MDUResult(res16)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic cur_busy(input bit s16);
    return s16 ? busy16 : busy32;
  endfunction

  function automatic logic [31:0] cur_res(input bit s16);
    return s16 ? {16'd0, res16} : res32;
  endfunction

  // Reference: HI/LO as one 2W-bit accumulator, results from plain integer arithmetic.
  function automatic void model(input int w, input int op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] hi, input logic [31:0] lo,
                                output logic [31:0] nhi, output logic [31:0] nlo);
    logic [63:0] mask, m2, ua, ub, acc, res;
    longint      sa, sb;
    mask = (64'd1 << w) - 64'd1;
    m2   = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (2 * w)) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = ua[w-1] ? longint'(ua | ~mask) : longint'(ua);
    sb   = ub[w-1] ? longint'(ub | ~mask) : longint'(ub);
    acc  = (({32'd0, hi} & mask) << w) | ({32'd0, lo} & mask);
    res  = acc;
    case (op)
      1:  res = 64'(sa * sb);
      2:  res = ua * ub;
      7:  res = acc + 64'(sa * sb);
      8:  res = acc + ua * ub;
      9:  res = acc - 64'(sa * sb);
      10: res = acc - ua * ub;
      3:  if (ub == 0) res = (ua << w) | mask;
          else res = ((64'(sa % sb) & mask) << w) | (64'(sa / sb) & mask);
      4:  if (ub == 0) res = (ua << w) | mask;
          else res = ((ua % ub) << w) | (ua / ub);
      5:  res = (ua << w) | (acc & mask);
      6:  res = (acc & ~mask) | ua;
      default: res = acc;
    endcase
    res = res & m2;
    nhi = 32'((res >> w) & mask);
    nlo = 32'(res & mask);
  endfunction

  task automatic run_op(input bit s16, input int op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_busy, input logic [31:0] eh, input logic [31:0] el,
                        input string tag);
    int          n;
    bit          stale_ok;
    logic [31:0] old_hi;
    @(negedge clk);
    chk({tag, "_idle_before"}, {31'd0, cur_busy(s16)}, 32'd0);
    old_hi = s16 ? m_hi16 : m_hi32;
    if (s16) begin
      a16 = a[15:0]; b16 = b[15:0]; op16 = op[3:0]; rd16 = 2'b10; st16 = 1'b1;
    end else begin
      a32 = a; b32 = b; op32 = op[3:0]; rd32 = 2'b10; st32 = 1'b1;
    end
    #1;
    n = 0;
    stale_ok = 1'b1;
    while (cur_busy(s16) && n < 100) begin
      n++;
      if (cur_res(s16) !== old_hi) stale_ok = 1'b0;
      @(negedge clk);
      st16 = 1'b0;
      st32 = 1'b0;
      #1;
    end
    chk({tag, "_busy_len"}, 32'(n), 32'(exp_busy));
    chk({tag, "_hi_stale_while_busy"}, {31'd0, stale_ok}, 32'd1);
    if (s16) rd16 = 2'b10; else rd32 = 2'b10;
    #1 chk({tag, "_hi"}, cur_res(s16), eh);
    if (s16) rd16 = 2'b01; else rd32 = 2'b01;
    #1 chk({tag, "_lo"}, cur_res(s16), el);
    if (s16) begin m_hi16 = eh; m_lo16 = el; end
    else     begin m_hi32 = eh; m_lo32 = el; end
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_8000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  function automatic int exp_len(input int op, input int w, input int lat);
    if (op == 1 || op == 2 || (op >= 7 && op <= 10)) return lat + 1;
    if (op == 3 || op == 4) return w + 2;
    return 1;
  endfunction

  initial begin
    logic [31:0] ra, rb, eh, el;
    int          op;
    reset = 1'b1;
    a32 = '0; b32 = '0; op32 = '0; rd32 = 2'b00; st32 = 1'b0; cancel32 = 1'b0;
    a16 = '0; b16 = '0; op16 = '0; rd16 = 2'b00; st16 = 1'b0; cancel16 = 1'b0;
    m_hi32 = '0; m_lo32 = '0; m_hi16 = '0; m_lo16 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    st32 = 1'b1;
    #1 chk("reset_busy_follows_start", {31'd0, busy32}, 32'd1);
    st32 = 1'b0;
    #1 chk("reset_busy_low", {31'd0, busy32}, 32'd0);
    rd32 = 2'b01;
    #1 chk("reset_lo", res32, 32'd0);
    rd32 = 2'b10;
    #1 chk("reset_hi", res32, 32'd0);
    rd16 = 2'b10;
    #1 chk("reset16_hi", cur_res(1'b1), 32'd0);
    chk("reset16_busy", {31'd0, busy16}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed 32-bit cases
    run_op(0, 1, 32'hFFFF_FFFE, 32'd3, 6, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
    run_op(0, 2, 32'hFFFF_FFFE, 32'd3, 6, 32'h0000_0002, 32'hFFFF_FFFA, "multu");
    run_op(0, 3, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
    run_op(0, 4, 32'd100, 32'd7, 34, 32'd2, 32'd14, "divu");
    run_op(0, 4, 32'h1234, 32'd0, 34, 32'h1234, 32'hFFFF_FFFF, "divu_by_zero");
    run_op(0, 3, 32'hFFFF_FFF9, 32'd0, 34, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by_zero_signed");
    run_op(0, 3, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000, "div_overflow");
    run_op(0, 5, 32'h11, 32'd0, 1, 32'h11, 32'h8000_0000, "mthi");
    run_op(0, 6, 32'h22, 32'd0, 1, 32'h11, 32'h22, "mtlo");
    rd32 = 2'b00;
    #1 chk("read_none", res32, 32'd0);
    rd32 = 2'b11;
    #1 chk("read_both_bits", res32, 32'd0);
    run_op(0, 7, 32'd2, 32'd3, 6, 32'h11, 32'h28, "madd");
    run_op(0, 10, 32'd1, 32'h29, 6, 32'h10, 32'hFFFF_FFFF, "msubu");
    run_op(0, 0, 32'h77, 32'h77, 1, 32'h10, 32'hFFFF_FFFF, "op0_ignored");
    run_op(0, 11, 32'h77, 32'h77, 1, 32'h10, 32'hFFFF_FFFF, "op11_ignored");

    // Reset in cycle 10 of a divide
    @(negedge clk);
    a32 = 32'hFFFF_FFF9; b32 = 32'd2; op32 = 4'd3; st32 = 1'b1;
    repeat (9) begin
      @(negedge clk);
      st32 = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1 chk("reset_mid_div_busy", {31'd0, busy32}, 32'd0);
    rd32 = 2'b10;
    #1 chk("reset_mid_div_hi", res32, 32'd0);
    rd32 = 2'b01;
    #1 chk("reset_mid_div_lo", res32, 32'd0);
    m_hi32 = '0; m_lo32 = '0; m_hi16 = '0; m_lo16 = '0;

`ifdef MDU_CANCEL_EN
    run_op(0, 5, 32'h55, 32'd0, 1, 32'h55, 32'd0, "cancel_pre_mthi");
    run_op(0, 6, 32'h66, 32'd0, 1, 32'h55, 32'h66, "cancel_pre_mtlo");
    @(negedge clk);
    a32 = 32'd100; b32 = 32'd7; op32 = 4'd4; st32 = 1'b1;
    repeat (9) begin
      @(negedge clk);
      st32 = 1'b0;
    end
    cancel32 = 1'b1;
    @(negedge clk);
    cancel32 = 1'b0;
    #1 chk("cancel_mid_div_busy", {31'd0, busy32}, 32'd0);
    rd32 = 2'b10;
    #1 chk("cancel_mid_div_hi", res32, 32'h55);
    rd32 = 2'b01;
    #1 chk("cancel_mid_div_lo", res32, 32'h66);
    @(negedge clk);
    a32 = 32'h99; op32 = 4'd5; st32 = 1'b1; cancel32 = 1'b1;
    @(negedge clk);
    st32 = 1'b0; cancel32 = 1'b0;
    #1 chk("cancel_start_busy", {31'd0, busy32}, 32'd0);
    rd32 = 2'b10;
    #1 chk("cancel_start_mthi_blocked", res32, 32'h55);
`endif

    // Randomized 32-bit ops against the model
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 11);
      ra = rnd_opnd();
      rb = rnd_opnd();
      model(32, op, ra, rb, m_hi32, m_lo32, eh, el);
      run_op(0, op, ra, rb, exp_len(op, 32, 5), eh, el, $sformatf("rnd32_%0d_op%0d", i, op));
    end

    // WIDTH=16, MUL_LAT=1 sweep
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 11);
      ra = rnd_opnd() & 32'h0000_FFFF;
      rb = rnd_opnd() & 32'h0000_FFFF;
      model(16, op, ra, rb, m_hi16, m_lo16, eh, el);
      run_op(1, op, ra, rb, exp_len(op, 16, 1), eh, el, $sformatf("rnd16_%0d_op%0d", i, op));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
